// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter: one registered owner index decoded to a one-hot grant,
// held until release. Define ARB_TIMEOUT_EN to revoke grants after MAX_HOLD cycles.
module rr_decode_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [IDX_W-1:0] idx_reg, idx_next;

    logic [N-1:0]     rot_req;
    logic [IDX_W-1:0] first_off;
    logic [IDX_W-1:0] sel_idx;
    logic             any_req;
    logic             release_now;

    // Rotate requests so bit 0 is the requester at ptr; N == 2**IDX_W makes the wrap free.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign rot_req[gi] = req[ptr_reg + IDX_W'(gi)];
        end
    endgenerate

    always_comb begin
        first_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                first_off = IDX_W'(i);
            end
        end
    end

    assign any_req     = |req;
    assign sel_idx     = ptr_reg + first_off;
    assign release_now = done || !req[idx_reg];

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              timeout_reg, timeout_next;
    logic              hold_limit;

    assign hold_limit = (hold_reg == HOLD_W'(MAX_HOLD - 1));
`endif

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        idx_next   = idx_reg;
`ifdef ARB_TIMEOUT_EN
        hold_next    = hold_reg;
        timeout_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    idx_next   = sel_idx;
                    ptr_next   = sel_idx + IDX_W'(1);
                    state_next = GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_next  = '0;
`endif
                end
            end
            GRANT: begin
                // A normal release wins over the hold limit on the same cycle.
                if (release_now) begin
                    state_next = IDLE;
`ifdef ARB_TIMEOUT_EN
                end else if (hold_limit) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end else begin
                    hold_next = hold_reg + HOLD_W'(1);
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            idx_reg   <= idx_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            hold_reg    <= hold_next;
            timeout_reg <= timeout_next;
        end
    end

    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

    // One-hot decode of the owner index, gated by ownership.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dec
            assign grant[gi] = (state_reg == GRANT) && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign grant_idx   = idx_reg;
    assign grant_valid = (state_reg == GRANT);

endmodule
